// File: rtl/dds_multiwave.sv
`default_nettype none
// ============================================================================
//  Module   : dds_multiwave
//  Purpose  : Phase-accumulator DDS producing sine/cosine/square/ramp/triangle
//             per sample, with shadowed frequency word and per-sample phase offset.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_multiwave #(
    parameter int M         = 24,
    parameter int L         = 15,
    parameter int W         = 16,
    parameter int SYNC_UPD  = 1,
    parameter     INIT_FILE = "rom_qw_L15_W16.txt"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] P,
    input  logic         P_load,
    input  logic [M-1:0] phase_off,
    input  logic [2:0]   mode,
    input  logic         val_in,
    input  logic         ena_ac,
    output logic [W-1:0] wave_out,
    output logic         val_out,
    output logic         wrap
);

    localparam int c_keep  = (L > W + 1) ? L : W + 1;
    localparam int c_aw    = L - 2;
    localparam int c_depth = 2 ** c_aw;
    localparam int c_tw    = W + 1;
    localparam real c_pi   = 3.14159265358979323846;
    localparam logic [c_keep-1:0] c_quarter  = {2'b01, {(c_keep-2){1'b0}}};
    localparam logic [W-1:0]      c_pos_full = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]      c_neg_full = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [W-1:0]      c_msb      = {1'b1, {(W-1){1'b0}}};
    // ROM contents are generated at elaboration from the same formula the init file holds.
    localparam int c_unused_init_bits = $bits(INIT_FILE);

    function automatic logic [W-1:0] rom_entry(input int k);
        real x;
        real term;
        real sum;
        x    = 2.0 * c_pi * (real'(k) + 0.5) / real'(2 ** L);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return W'($rtoi(real'(2 ** (W - 1) - 1) * sum + 0.5));
    endfunction

    logic [W-1:0] w_rom [c_depth];
    for (genvar g = 0; g < c_depth; g++) begin : g_rom
        localparam logic [W-1:0] c_val = rom_entry(g);
        assign w_rom[g] = c_val;
    end

    logic [M-1:0]      r_acc, r_inc, r_shad;
    logic              r_pend;
    logic [M:0]        w_acc_sum;
    logic              w_carry, w_apply;
    logic [M-1:0]      w_ph_sum;
    logic [c_keep-1:0] w_ph_s2;
    logic [c_aw-1:0]   w_addr;
    logic [W-1:0]      w_wave;

    logic [c_keep-1:0] r_ph1;
    logic [c_tw-1:0]   r_ph2, r_ph3;
    logic [2:0]        r_mode1, r_mode2, r_mode3;
    logic              r_v1, r_v2, r_v3;
    logic [c_aw-1:0]   r_addr;
    logic [W-1:0]      r_q;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry   = ena_ac & val_in & w_acc_sum[M];
    // With the accumulator stopped or idle no wrap can come, so a pending word applies at once.
    assign w_apply   = r_pend & ((SYNC_UPD == 0) | w_carry | ~ena_ac | (r_inc == '0));

    assign w_ph_sum = r_acc + phase_off;
    if (c_keep < M) begin : g_lo_bits
        logic w_unused_lo;
        assign w_unused_lo = ^w_ph_sum[M-c_keep-1:0];
    end

    assign w_ph_s2 = r_ph1 + ((r_mode1 == 3'd1) ? c_quarter : '0);
    assign w_addr  = w_ph_s2[c_keep-3 -: c_aw] ^ {c_aw{w_ph_s2[c_keep-2]}};

    always_comb begin
        w_wave = '0;
        case (r_mode3)
            3'd0, 3'd1: w_wave = r_ph3[W] ? (-r_q) : r_q;
            3'd2:       w_wave = r_ph3[W] ? c_neg_full : c_pos_full;
            3'd3:       w_wave = {~r_ph3[W], r_ph3[W-1:1]};
            3'd4:       w_wave = (r_ph3[W-1:0] ^ {W{r_ph3[W]}}) ^ c_msb;
            default:    w_wave = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_inc  <= '0;
            r_shad <= '0;
            r_pend <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            if (!ena_ac) begin
                r_acc <= '0;
            end else if (val_in) begin
                r_acc <= w_acc_sum[M-1:0];
            end
            wrap <= w_carry;
            if (w_apply) begin
                r_inc <= r_shad;
            end
            if (P_load) begin
                r_shad <= P;
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph1    <= '0;
            r_ph2    <= '0;
            r_ph3    <= '0;
            r_mode1  <= '0;
            r_mode2  <= '0;
            r_mode3  <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_addr   <= '0;
            r_q      <= '0;
            wave_out <= '0;
            val_out  <= 1'b0;
        end else begin
            r_ph1   <= w_ph_sum[M-1 -: c_keep];
            r_mode1 <= mode;
            r_v1    <= val_in;
            r_addr  <= w_addr;
            r_ph2   <= w_ph_s2[c_keep-1 -: c_tw];
            r_mode2 <= r_mode1;
            r_v2    <= r_v1;
            r_q     <= w_rom[r_addr];
            r_ph3   <= r_ph2;
            r_mode3 <= r_mode2;
            r_v3    <= r_v2;
            if (r_v3) begin
                wave_out <= w_wave;
            end
            val_out <= r_v3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_multiwave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_multiwave
//  Purpose  : Scoreboard bench for dds_multiwave against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_multiwave;

    localparam int     M    = 24;
    localparam int     L    = 15;
    localparam int     W    = 16;
    localparam longint MOD  = longint'(1) << M;
    localparam int     HALF = 1 << (W - 1);
    localparam int     AMPI = (1 << (W - 1)) - 1;
    localparam real    PI   = 3.14159265358979323846;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [M-1:0] P = '0;
    logic         P_load = 1'b0;
    logic [M-1:0] phase_off = '0;
    logic [2:0]   mode = '0;
    logic         val_in = 1'b0;
    logic         ena_ac = 1'b0;
    logic [W-1:0] wave_out;
    logic         val_out;
    logic         wrap;

    always #5 clk = ~clk;

    dds_multiwave #(.M(M), .L(L), .W(W), .SYNC_UPD(1)) dut (
        .clk(clk), .rst_n(rst_n), .P(P), .P_load(P_load), .phase_off(phase_off),
        .mode(mode), .val_in(val_in), .ena_ac(ena_ac),
        .wave_out(wave_out), .val_out(val_out), .wrap(wrap)
    );

    typedef struct { int val; int cyc; } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_wrap = 0;
    longint m_acc = 0, m_inc = 0, m_shad = 0;
    bit m_pend = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal waveform for a given phase, straight from the waveform definitions.
    function automatic int exp_wave(input int md, input longint ph);
        longint u, j;
        real s;
        case (md)
            0, 1: begin
                if (md == 1) ph = (ph + (MOD >> 2)) % MOD;
                j = ph >> (M - L);
                s = real'(AMPI) * $sin(2.0 * PI * (real'(j) + 0.5) / real'(longint'(1) << L));
                return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
            end
            2: return (ph >= MOD / 2) ? -AMPI : AMPI;
            3: return int'(ph >> (M - W)) - HALF;
            4: begin
                u = ph >> (M - W - 1);
                if (u < (longint'(1) << W)) return int'(u) - HALF;
                return int'(((longint'(1) << (W + 1)) - 1) - u) - HALF;
            end
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_sample: got none expected %0d at cycle %0d", sb[0].val, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (val_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_val_out: got val_out=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("sample_time", cyc, e.cyc);
                    check("wave_out", int'($signed(wave_out)), e.val);
                end
            end
        end
    end

    task automatic step(input bit v, input bit e, input bit ld, input longint p,
                        input longint po, input int md);
        longint sum;
        bit carry, apply;
        exp_t x;
        val_in = v; ena_ac = e; P_load = ld;
        P = p[M-1:0]; phase_off = po[M-1:0]; mode = md[2:0];
        if (v) begin
            x.val = exp_wave(md, (m_acc + po) % MOD);
            x.cyc = cyc + 4;
            sb.push_back(x);
        end
        sum   = m_acc + m_inc;
        carry = v && e && (sum >= MOD);
        apply = m_pend && (carry || !e || (m_inc == 0));
        if (!e) m_acc = 0;
        else if (v) m_acc = sum % MOD;
        if (apply) m_inc = m_shad;
        if (ld) begin
            m_shad = p;
            m_pend = 1;
        end else if (apply) begin
            m_pend = 0;
        end
        @(posedge clk);
        #1;
        last_wrap = int'(wrap);
        check("wrap", int'(wrap), int'(carry));
    endtask

    task automatic reset_mid();
        rst_n = 1'b0; val_in = 1'b0; P_load = 1'b0;
        #1;
        check("rst_wave_out", int'(wave_out), 0);
        check("rst_val_out", int'(val_out), 0);
        check("rst_wrap", int'(wrap), 0);
        sb.delete();
        m_acc = 0; m_inc = 0; m_shad = 0; m_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        check("reset_wave_out", int'(wave_out), 0);
        check("reset_val_out", int'(val_out), 0);
        check("reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;

        // Ramp with P=0x100000, then triangle, sine and cosine.
        step(0, 1, 1, 'h100000, 0, 3);
        step(0, 1, 0, 0, 0, 3);
        repeat (40) step(1, 1, 0, 0, 0, 3);
        repeat (16) step(1, 1, 0, 0, 0, 4);
        repeat (16) step(1, 1, 0, 0, 0, 0);
        repeat (16) step(1, 1, 0, 0, 0, 1);

        // Wrap-synchronous increment update loaded mid-period.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 1, 0, 0, 0, 3);
            seen = (last_wrap != 0);
        end
        check("wrap_found_before_update", int'(seen), 1);
        repeat (5) step(1, 1, 0, 0, 0, 3);
        step(1, 1, 1, 'h200000, 0, 3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 1, 0, 0, 0, 3);
            seen = (last_wrap != 0);
        end
        check("wrap_found_after_update", int'(seen), 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 1, 0, 0, 0, 3);
            n++;
            seen = (last_wrap != 0);
        end
        check("period_after_update", n, 8);

        // Phase offset with square, then per-sample mode toggling.
        step(0, 0, 0, 0, 0, 2);
        step(1, 1, 0, 0, 'h400000, 2);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 'h400000, (i % 2 == 0) ? 3 : 2);

        // Gaps hold the accumulator; ena_ac=0 restarts the ramp.
        for (int i = 0; i < 12; i++) step(i % 3 != 0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 3);
        repeat (6) step(1, 1, 0, 0, 0, 3);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            longint p;
            if (i == 700) begin
                reset_mid();
                step(0, 1, 1, 'h080000, 0, 3);
            end
            p = ($urandom_range(0, 9) == 0) ? 0 : longint'($urandom_range(1, 'h0FFFFF));
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < 3, p, longint'($urandom & 32'h00FF_FFFF),
                 int'($urandom_range(0, 7)));
        end

        repeat (6) step(0, 1, 0, 0, 0, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
